mem_reader_arbiter: RTL

Round-robin scheduler that shares the single AXI Memory Reader between `N_REQ` log-fetch clients (CFI, IDFI, DDFI, and future monitors). Each client requests a multi-word read with a base address and word count. The arbiter sequences one word read at a time into the reader, streams each returned word back to the granted client, and reports completion or error per client. It replaces per-client polling with fair, starvation-free, timeout-protected access.

---
 rtl/log_access_pkg.sv | 26 ++
 rtl/rr_pick.sv | 29 ++
 rtl/mem_reader_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/log_access_pkg.sv
// Shared types and constants for the log-fetch memory access path.
// Used by the reader arbiter and its round-robin picker.
package log_access_pkg;

    localparam int MAX_WORDS_DEF  = 4;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int LEN_W          = $clog2(MAX_WORDS_DEF + 1);
    localparam int BYTE_STEP      = DATA_WIDTH_DEF / 8;

    localparam int CLIENT_CFI  = 0;
    localparam int CLIENT_IDFI = 1;
    localparam int CLIENT_DDFI = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FINISH
    } state_e;

    // Address increment between consecutive beats of one transaction.
    function automatic int beat_step(input int dw);
        return dw / 8;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester strictly after
// the last owner, scanning cyclically.
module rr_pick #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [IW-1:0] k;

    // Scan offsets 1..N from the last owner; the first hit wins.
    always_comb begin
        grant = '0;
        valid = 1'b0;
        k     = '0;
        for (int i = 1; i <= N; i++) begin
            k = IW'((int'(last) + i) % N);
            if (!valid && req[k]) begin
                grant[k] = 1'b1;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_reader_arbiter.sv
// Round-robin sharing of one single-word memory reader between clients,
// with per-beat timeout and per-client done/error reporting.
module mem_reader_arbiter
    import log_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int N_REQ      = 3,
    parameter int MAX_WORDS  = 4,
    parameter int TIMEOUT    = 1024,
    localparam int LW = $clog2(MAX_WORDS + 1),
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            i_req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] i_addr,
    input  logic [N_REQ*LW-1:0]         i_len,
    output logic [N_REQ-1:0]            o_grant,
    output logic                        o_valid,
    output logic [DATA_WIDTH-1:0]       o_data,
    output logic [LW-1:0]               o_beat,
    output logic [N_REQ-1:0]            o_done,
    output logic [N_REQ-1:0]            o_err,
    output logic [ADDR_WIDTH-1:0]       o_mem_addr,
    output logic                        o_read_trigger,
    input  logic [DATA_WIDTH-1:0]       i_mem_value,
    input  logic                        i_done,
    input  logic                        i_error
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] STEP =
        ADDR_WIDTH'(beat_step(DATA_WIDTH));
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_WORDS);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [IW-1:0]         last_q, last_d;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         beat_q, beat_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  err_q, err_d;

    logic [N_REQ-1:0]      pick_grant;
    logic                  pick_valid;
    logic [IW-1:0]         pick_idx;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [LW-1:0]         pick_len_raw;
    logic [LW-1:0]         pick_len;
    logic                  beat_last;

    rr_pick #(
        .N(N_REQ)
    ) u_pick (
        .req   (i_req),
        .last  (last_q),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // Decode the one-hot pick into index, base address and clamped length.
    always_comb begin
        pick_idx     = '0;
        pick_addr    = '0;
        pick_len_raw = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick_grant[k]) begin
                pick_idx     = IW'(k);
                pick_addr    = i_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
                pick_len_raw = i_len[k*LW +: LW];
            end
        end
        pick_len = (pick_len_raw > LEN_MAX) ? LEN_MAX : pick_len_raw;
    end

    assign beat_last = ((beat_q + LW'(1)) == len_q);
    assign o_grant   = grant_q;

    // Next-state and output logic of the transaction sequencer.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        last_d         = last_q;
        grant_d        = grant_q;
        addr_d         = addr_q;
        len_d          = len_q;
        beat_d         = beat_q;
        tmo_d          = tmo_q;
        err_d          = err_q;
        o_valid        = 1'b0;
        o_data         = '0;
        o_beat         = '0;
        o_done         = '0;
        o_err          = '0;
        o_mem_addr     = '0;
        o_read_trigger = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    grant_d = pick_grant;
                    addr_d  = pick_addr;
                    len_d   = pick_len;
                    beat_d  = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    state_d = (pick_len == '0) ? ST_FINISH : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                o_read_trigger = 1'b1;
                o_mem_addr     = addr_q;
                tmo_d          = '0;
                state_d        = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_error || (tmo_q == TMO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = ST_FINISH;
                end else if (i_done) begin
                    o_valid = 1'b1;
                    o_data  = i_mem_value;
                    o_beat  = beat_q;
                    beat_d  = beat_q + LW'(1);
                    addr_d  = addr_q + STEP;
                    state_d = beat_last ? ST_FINISH : ST_ISSUE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_FINISH: begin
                for (int k = 0; k < N_REQ; k++) begin
                    if (idx_q == IW'(k)) begin
                        o_err[k]  = err_q;
                        o_done[k] = ~err_q;
                    end
                end
                last_d  = idx_q;
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any transaction silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            grant_q <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            beat_q  <= beat_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

endmodule
